// File: rtl/convolution_coprocessor_demux_if.sv
// Stream and dual-channel bus of the convolution coprocessor result demux.
// The demux connects through the slave modport; the source/sink side uses the master modport.
interface convolution_coprocessor_demux_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sel;
    logic                  in_valid;
    logic                  in_ready;

    logic [DATA_WIDTH-1:0] out_a_data;
    logic [ADDR_WIDTH-1:0] out_a_addr;
    logic                  out_a_valid;
    logic                  out_a_ready;

    logic [DATA_WIDTH-1:0] out_b_data;
    logic [ADDR_WIDTH-1:0] out_b_addr;
    logic                  out_b_valid;
    logic                  out_b_ready;

    modport slave (
        input  in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        output in_ready,
        output out_a_data, out_a_addr, out_a_valid,
        output out_b_data, out_b_addr, out_b_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        input  in_ready,
        input  out_a_data, out_a_addr, out_a_valid,
        input  out_b_data, out_b_addr, out_b_valid
    );
endinterface

// File: rtl/convolution_coprocessor_demux.sv
// 1-to-2 result router with LEN-beat job framing (start/busy/done).
// CONVOLUTION_COPROCESSOR_DEMUX_ADDR_EN builds per-channel write address counters; otherwise addr outputs are 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting beats until the beat counter reaches 0
// DRAIN | all beats accepted, waiting for both channels to empty
// DONE  | one-cycle done pulse, then back to IDLE
module convolution_coprocessor_demux #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    convolution_coprocessor_demux_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] beats;
    logic                 a_free;
    logic                 b_free;
    logic                 accept;
    logic                 load_a;
    logic                 load_b;

    // A channel can take a new sample in the same cycle its current one is consumed.
    assign a_free       = !bus.out_a_valid || bus.out_a_ready;
    assign b_free       = !bus.out_b_valid || bus.out_b_ready;
    assign bus.in_ready = (state == RUN) && (bus.in_sel ? b_free : a_free);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_a       = accept && !bus.in_sel;
    assign load_b       = accept && bus.in_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beats <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        beats <= len;
                        busy  <= 1'b1;
                        state <= (len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        beats <= beats - 1'b1;
                        if (beats == LEN_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.out_a_valid && !bus.out_b_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_a_data  <= '0;
            bus.out_a_valid <= 1'b0;
            bus.out_b_data  <= '0;
            bus.out_b_valid <= 1'b0;
        end else begin
            if (load_a) begin
                bus.out_a_data  <= bus.in_data;
                bus.out_a_valid <= 1'b1;
            end else if (bus.out_a_valid && bus.out_a_ready) begin
                bus.out_a_valid <= 1'b0;
            end
            if (load_b) begin
                bus.out_b_data  <= bus.in_data;
                bus.out_b_valid <= 1'b1;
            end else if (bus.out_b_valid && bus.out_b_ready) begin
                bus.out_b_valid <= 1'b0;
            end
        end
    end

`ifdef CONVOLUTION_COPROCESSOR_DEMUX_ADDR_EN
    logic [ADDR_WIDTH-1:0] a_cnt;
    logic [ADDR_WIDTH-1:0] b_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt          <= '0;
            b_cnt          <= '0;
            bus.out_a_addr <= '0;
            bus.out_b_addr <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_cnt <= '0;
                b_cnt <= '0;
            end
            if (load_a) begin
                bus.out_a_addr <= a_cnt;
                a_cnt          <= a_cnt + 1'b1;
            end
            if (load_b) begin
                bus.out_b_addr <= b_cnt;
                b_cnt          <= b_cnt + 1'b1;
            end
        end
    end
`else
    assign bus.out_a_addr = '0;
    assign bus.out_b_addr = '0;
`endif
endmodule

// File: tb/tb_convolution_coprocessor_demux.sv
// Scoreboard bench for convolution_coprocessor_demux: expected samples queue on acceptance, pop on channel handshake.
module tb_convolution_coprocessor_demux;
    localparam int DW = 6;
    localparam int AW = 5;
    localparam int LW = 8;
`ifdef CONVOLUTION_COPROCESSOR_DEMUX_ADDR_EN
    localparam bit ADDR_ON = 1'b1;
`else
    localparam bit ADDR_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len   = '0;
    logic          busy;
    logic          done;

    convolution_coprocessor_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    convolution_coprocessor_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } item_t;

    item_t         q_a[$];
    item_t         q_b[$];
    item_t         ea;
    item_t         eb;
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] na = '0;
    logic [AW-1:0] nb = '0;

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] c);
        return c & {AW{ADDR_ON}};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_a_valid && bus.out_a_ready) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL mon_a_unexpected data=%0d addr=%0d required none", bus.out_a_data, bus.out_a_addr);
            end else begin
                ea = q_a.pop_front();
                if ({bus.out_a_data, bus.out_a_addr} !== ea) begin
                    errors++;
                    $display("FAIL mon_a data=%0d addr=%0d required data=%0d addr=%0d",
                             bus.out_a_data, bus.out_a_addr, ea.d, ea.a);
                end
            end
        end
        if (!rst && bus.out_b_valid && bus.out_b_ready) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL mon_b_unexpected data=%0d addr=%0d required none", bus.out_b_data, bus.out_b_addr);
            end else begin
                eb = q_b.pop_front();
                if ({bus.out_b_data, bus.out_b_addr} !== eb) begin
                    errors++;
                    $display("FAIL mon_b data=%0d addr=%0d required data=%0d addr=%0d",
                             bus.out_b_data, bus.out_b_addr, eb.d, eb.a);
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic start_job(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        na    = '0;
        nb    = '0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic s);
        int            n;
        logic [AW-1:0] ad;
        item_t         it;
        logic [DW+AW:0] obs;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
            #1;
            bus.in_valid = 1'b0;
        end else begin
            ad   = model_addr(s ? nb : na);
            it.d = d;
            it.a = ad;
            if (s) begin q_b.push_back(it); nb++; end
            else   begin q_a.push_back(it); na++; end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            obs = s ? {bus.out_b_valid, bus.out_b_data, bus.out_b_addr}
                    : {bus.out_a_valid, bus.out_a_data, bus.out_a_addr};
            checks++;
            if (obs !== {1'b1, d, ad}) begin
                errors++;
                $display("FAIL visible_%s valid/data/addr=%b/%0d/%0d required 1/%0d/%0d",
                         s ? "b" : "a", obs[DW+AW], obs[DW+AW-1:AW], obs[AW-1:0], d, ad);
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout done=%b required 1", name, done);
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_at_done busy=%b required 0", name, busy);
            end
            repeat (3) begin
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_after_done done=%b busy=%b required 0/0", name, done, busy);
                end
            end
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending_a=%0d pending_b=%0d required 0/0", name, q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_a_valid, bus.out_b_valid, busy, done} !== 5'b0 ||
            {bus.out_a_data, bus.out_b_data, bus.out_a_addr, bus.out_b_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state rdy/va/vb/busy/done=%b%b%b%b%b da=%0d db=%0d aa=%0d ab=%0d required all 0",
                     bus.in_ready, bus.out_a_valid, bus.out_b_valid, busy, done,
                     bus.out_a_data, bus.out_b_data, bus.out_a_addr, bus.out_b_addr);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alternating();
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        start_job(LW'(4));
        send_beat(DW'(5), 1'b0);
        send_beat(DW'(-3), 1'b1);
        send_beat(DW'(31), 1'b0);
        send_beat(DW'(-32), 1'b1);
        wait_done("alternating");
    endtask

    task automatic test_backpressure();
        bus.out_a_ready = 1'b0;
        bus.out_b_ready = 1'b1;
        start_job(LW'(3));
        send_beat(DW'(7), 1'b0);
        bus.in_data  = DW'(1);
        bus.in_sel   = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_a_valid !== 1'b1 || bus.out_a_data !== DW'(7)) begin
                errors++;
                $display("FAIL bp_stall in_ready=%b va=%b da=%0d required 0/1/7",
                         bus.in_ready, bus.out_a_valid, bus.out_a_data);
            end
            @(posedge clk); #1;
        end
        send_beat(DW'(2), 1'b1);
        checks++;
        if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== DW'(7)) begin
            errors++;
            $display("FAIL bp_a_undisturbed va=%b da=%0d required 1/7", bus.out_a_valid, bus.out_a_data);
        end
        bus.out_a_ready = 1'b1;
        send_beat(DW'(1), 1'b0);
        wait_done("backpressure");
    endtask

    task automatic test_wrap();
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        start_job(LW'(33));
        for (int i = 0; i < 33; i++) send_beat(DW'(i * 7 - 20), 1'b0);
        wait_done("wrap");
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len   = '0;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL len0_drain in_ready=%b busy=%b done=%b required 0/1/0", bus.in_ready, busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_done done=%b busy=%b in_ready=%b required 1/0/0", done, busy, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_after done=%b in_ready=%b required 0/0", done, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        start_job(LW'(2));
        send_beat(DW'(4), 1'b0);
        start = 1'b1;
        len   = LW'(5);
        send_beat(DW'(6), 1'b0);
        start = 1'b0;
        wait_done("start_ignored");
    endtask

    task automatic test_rst_mid_run();
        bus.out_a_ready = 1'b0;
        bus.out_b_ready = 1'b1;
        start_job(LW'(3));
        send_beat(DW'(9), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_a_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort va=%b busy=%b done=%b in_ready=%b required 0/0/0/0",
                     bus.out_a_valid, busy, done, bus.in_ready);
        end
        rst = 1'b0;
        q_a.delete();
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done done=%b busy=%b required 0/0", done, busy);
            end
        end
        bus.out_a_ready = 1'b1;
    endtask

    initial begin
        bus.in_data     = '0;
        bus.in_sel      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        #1;
        test_reset();
        test_alternating();
        test_backpressure();
        test_wrap();
        test_len_zero();
        test_start_ignored();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/convolution_coprocessor_demux.md
# convolution_coprocessor_demux

Sequential 1-to-2 result router for the convolution coprocessor. It accepts a valid/ready stream of signed convolution results, each tagged with a select bit, and steers every beat into one of two registered output channels (A or B) with independent handshakes and per-channel write addresses. It sits at the coprocessor output, where it distributes results to two destination memories. It also frames a job of LEN beats with start/done control.

## Interface
Parameters:
- DATA_WIDTH, 6, width of each signed result sample
- ADDR_WIDTH, 5, width of each per-channel write address counter
- LEN_WIDTH, 8, width of the job-length input and the beat counter

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset; synchronous and active-high
- start  input  1  one-cycle pulse that begins a job; honoured only in IDLE
- len  input  LEN_WIDTH  number of beats in the job; sampled when start is accepted
- in_data  input  DATA_WIDTH  signed result sample
- in_sel  input  1  channel select; 0 = A, 1 = B; qualified by in_valid
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block accepts the beat this cycle
- out_a_data / out_b_data  output  DATA_WIDTH  registered sample for each channel
- out_a_addr / out_b_addr  output  ADDR_WIDTH  write address of the sample held in the channel
- out_a_valid / out_b_valid  output  1  channel register holds a sample
- out_a_ready / out_b_ready  input  1  downstream consumes the channel sample
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when a job completes

## Operation
- FSM states are IDLE, RUN, DRAIN, and DONE.
- IDLE -> RUN on start with len != 0. IDLE -> DRAIN on start with len == 0.
- On start, the beat counter loads len and both address counters clear to 0.
- RUN: a beat is accepted when in_valid && in_ready.
  - in_ready = (state == RUN) && target channel free.
  - A channel is free when its valid is 0, or when its valid and ready are both 1 in the same cycle.
  - The combinational dependency of in_ready on in_sel is intended.
- An accepted beat does three things:
  - It loads data into the selected channel register, sets that channel's valid, and writes the channel's current address counter to out_x_addr.
  - It increments that channel's address counter, wrapping from 2^ADDR_WIDTH-1 to 0.
  - It decrements the beat counter.
- RUN -> DRAIN when the beat counter reaches 0, i.e. in the cycle the last beat is accepted.
- DRAIN -> DONE when both out_a_valid and out_b_valid are 0. DONE -> IDLE unconditionally after one cycle.
- Channel register update: if a load occurs, valid is 1 and the new data is captured. Otherwise, valid clears when valid && ready.
- Data and addr hold their values while valid && !ready.
- The unselected channel is never disturbed by a beat.
- start outside IDLE is ignored. in_valid outside RUN is ignored (in_ready = 0).
- Data passes through unmodified; it is signed two's complement with no width change.
- Reset values: state IDLE; all valids, in_ready, busy, and done are 0; data, addr, and all counters are 0.
- rst asserted mid-job aborts it. At the next edge, held samples are discarded and done is not pulsed.

## Timing
- Latency: a beat accepted at edge N is visible on out_x_data/valid after edge N.
- Throughput: one beat per cycle when the target channel's ready is held at 1, including back-to-back beats to the same channel.
- Backpressure on one channel stalls the input only for beats targeting that channel. The other channel keeps draining.
- done asserts exactly one cycle, at least one cycle after the last channel handshake.
- busy falls in the same cycle that done rises.

## Configuration
- CONVOLUTION_COPROCESSOR_DEMUX_ADDR_EN:
  - Defined: address counters exist and out_a_addr/out_b_addr behave as specified.
  - Undefined: the counters are not built and both addr outputs are constant 0. All other behaviour is identical.

## Test plan
- Reset state: rst high for 2 cycles -> all outputs 0, in_ready 0, state IDLE.
- Alternating stream: start, len=4, beats (+5,A),(-3,B),(+31,A),(-32,B), both readies held 1 -> A gets +5@addr0 then +31@addr1, B gets -3@addr0 then -32@addr1; each beat is visible one cycle after acceptance; done pulses once.
- Backpressure isolation: out_a_ready=0, beats (7,A),(1,A),(2,B) -> the second A beat stalls with in_ready=0, and B still receives 2 at the next cycle; raising out_a_ready lets 1 enter A.
- Address wrap (ADDR_EN defined, ADDR_WIDTH=5): 33 beats to A -> addresses run 0..31, then 0; done follows the final drain.
- Boundary conditions:
  - start with len=0 -> DRAIN, then a done pulse 2 cycles after start, with no in_ready.
  - start during RUN is ignored.
  - rst during RUN with A holding data -> out_a_valid 0 after the edge, and no done.
- Macro off: rerun the alternating stream -> identical data/valid/done behaviour, with addr outputs stuck at 0.
